// File: rtl/toi2s_i2s_tx_multi.sv
// toi2s_i2s_tx_multi
// Multi-line I2S / left-justified transmitter. Frames of 2*NPAIR signed PCM
// samples arrive over a valid/ready handshake into a one-entry holding
// register, are moved to a shadow register at each frame boundary, and are
// serialised MSB first onto NPAIR data lines sharing one BCK/WS pair.
//
// Ports
//   clk, resetb       system clock, asynchronous active-low reset
//   ena               run enable (low clears divider, bit counter, shadow and
//                     the serial outputs; the holding register is kept)
//   mode              0 = I2S (WS one BCK ahead of data), 1 = left-justified
//   mute              zero the frame loaded at a boundary
//   s_data            pair p: left [2p*SAMPLE_W +: SAMPLE_W],
//                     right [(2p+1)*SAMPLE_W +: SAMPLE_W]
//   s_valid, s_ready  input frame handshake, s_ready = holding register empty
//   i2s_bck, i2s_ws   bit clock and word select (0 = left)
//   i2s_d             one serial data line per stereo pair
//   frame_start       one-clk pulse when the bit counter wraps at a boundary
//   underrun          sticky, set when a boundary finds no frame waiting
//   underrun_clr      clears underrun (a same-cycle new underrun wins)
module toi2s_i2s_tx_multi #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int NPAIR    = 1,
  parameter int BCK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic                        ena,
  input  logic                        mode,
  input  logic                        mute,
  input  logic [2*NPAIR*SAMPLE_W-1:0] s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        i2s_bck,
  output logic                        i2s_ws,
  output logic [NPAIR-1:0]            i2s_d,
  output logic                        frame_start,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  localparam int          FW       = 2 * NPAIR * SAMPLE_W;
  localparam int unsigned FRAME_U  = 2 * SLOT_W;
  localparam int unsigned SLOT_U   = SLOT_W;
  localparam int unsigned SAMPLE_U = SAMPLE_W;
  localparam int          BW       = $clog2(2 * SLOT_W);
  localparam int          DW       = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

  logic [DW-1:0]    div_q;
  logic             bck_q;
  logic [BW-1:0]    bit_q;
  logic [BW-1:0]    bit_nxt;
  logic [FW-1:0]    s_q;
  logic [FW-1:0]    s_nxt;
  logic [FW-1:0]    h_q;
  logic             h_full;
  logic             ws_q;
  logic             ws_nxt;
  logic [NPAIR-1:0] d_q;
  logic [NPAIR-1:0] d_nxt;
  logic             fs_q;
  logic             ur_q;

  logic             tc;
  logic             fall;
  logic             boundary;
  logic             xfer;
  int unsigned      bn;
  int unsigned      kk;
  int unsigned      chn;
  logic             k_ok;

  // Next bit position and shadow contents; the serial outputs are registered
  // from these so WS/data change on the same edge that drives BCK low.
  always_comb begin
    tc       = (div_q == DIV_LAST);
    fall     = ena & tc & bck_q;
    boundary = fall & (bit_q == BIT_LAST);
    xfer     = s_valid & ~h_full;

    bit_nxt = bit_q;
    if (boundary) begin
      bit_nxt = '0;
    end else if (fall) begin
      bit_nxt = bit_q + BW'(1);
    end

    s_nxt = s_q;
    if (boundary) begin
      s_nxt = (h_full && !mute) ? h_q : '0;
    end

    bn   = 32'(bit_nxt);
    chn  = (bn >= SLOT_U) ? 32'd1 : 32'd0;
    kk   = bn - chn * SLOT_U;
    k_ok = (kk < SAMPLE_U);

    if (mode) begin
      ws_nxt = (chn != 0);
    end else begin
      ws_nxt = (((bn + 1) % FRAME_U) >= SLOT_U);
    end

    // Pairs are shifted in from the top so no variable bit index is needed.
    d_nxt = '0;
    for (int unsigned p = NPAIR; p > 0; p--) begin
      d_nxt = (d_nxt << 1) |
              NPAIR'(k_ok & (|((s_nxt >> ((2 * (p - 1) + chn) * SAMPLE_U +
                                          SAMPLE_U - 1 - kk)) & FW'(1))));
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q  <= '0;
      bck_q  <= 1'b0;
      bit_q  <= '0;
      s_q    <= '0;
      h_q    <= '0;
      h_full <= 1'b0;
      ws_q   <= 1'b0;
      d_q    <= '0;
      fs_q   <= 1'b0;
      ur_q   <= 1'b0;
    end else begin
      // Holding register: the boundary sees H before any same-cycle transfer.
      if (boundary && h_full) begin
        h_full <= 1'b0;
      end else if (xfer) begin
        h_full <= 1'b1;
        h_q    <= s_data;
      end

      if (boundary && !h_full) begin
        ur_q <= 1'b1;
      end else if (underrun_clr) begin
        ur_q <= 1'b0;
      end

      if (!ena) begin
        div_q <= '0;
        bck_q <= 1'b0;
        bit_q <= '0;
        s_q   <= '0;
        ws_q  <= 1'b0;
        d_q   <= '0;
        fs_q  <= 1'b0;
      end else begin
        div_q <= tc ? '0 : div_q + DW'(1);
        if (tc) begin
          bck_q <= ~bck_q;
        end
        bit_q <= bit_nxt;
        s_q   <= s_nxt;
        if (fall) begin
          ws_q <= ws_nxt;
          d_q  <= d_nxt;
        end
        fs_q <= boundary;
      end
    end
  end

  assign s_ready     = ~h_full;
  assign i2s_bck     = bck_q;
  assign i2s_ws      = ws_q;
  assign i2s_d       = d_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_toi2s_i2s_tx_multi.sv
// Directed bench for toi2s_i2s_tx_multi with two stereo pairs and default
// sample/slot/divider sizes. Inputs are driven and outputs sampled on the
// falling clk edge; each serial bit is sampled mid-bit.
module tb_toi2s_i2s_tx_multi;

  localparam int SW = 24;
  localparam int SLW = 32;
  localparam int NP = 2;
  localparam int BD = 4;

  logic              clk = 1'b0;
  logic              resetb;
  logic              ena;
  logic              mode;
  logic              mute;
  logic [2*NP*SW-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              i2s_bck;
  logic              i2s_ws;
  logic [NP-1:0]     i2s_d;
  logic              frame_start;
  logic              underrun;
  logic              underrun_clr;

  always #5 clk = ~clk;

  toi2s_i2s_tx_multi #(
    .SAMPLE_W(SW),
    .SLOT_W  (SLW),
    .NPAIR   (NP),
    .BCK_DIV (BD)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .ena         (ena),
    .mode        (mode),
    .mute        (mute),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .i2s_bck     (i2s_bck),
    .i2s_ws      (i2s_ws),
    .i2s_d       (i2s_d),
    .frame_start (frame_start),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  // Frames packed as {R1, L1, R0, L0}.
  localparam logic [95:0] FR_A  = {24'h800000, 24'h000001, 24'h7FFFFF, 24'h800001};
  localparam logic [95:0] FR_FA = {24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
  localparam logic [95:0] FR_FB = {24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
  localparam logic [95:0] FR_FC = {24'h000001, 24'h800000, 24'h00000F, 24'hF00000};

  // Expected serial line contents, bit i of the vector = frame bit i.
  localparam logic [63:0] WS_LJ  = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] WS_I2S = 64'h7FFFFFFF_80000000;
  localparam logic [63:0] A_D0   = 64'h00FFFFFE_00800001;
  localparam logic [63:0] A_D1   = 64'h00000001_00800000;
  localparam logic [63:0] FA_D0  = 64'h00000000_00FFFFFF;
  localparam logic [63:0] FA_D1  = 64'h00FFFFFF_00000000;
  localparam logic [63:0] FB_D0  = 64'h00FFFFFF_00000000;
  localparam logic [63:0] FB_D1  = 64'h00000000_00FFFFFF;
  localparam logic [63:0] FC_D0  = 64'h00F00000_0000000F;
  localparam logic [63:0] FC_D1  = 64'h00800000_00000001;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [63:0]   cws;
  logic [63:0]   cd0;
  logic [63:0]   cd1;
  logic [NP-1:0] dor;
  logic          bor;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step falling edges until frame_start is seen; ORs the data lines seen
  // before the pulse.
  task automatic wait_fs(input int unsigned budget, input string tag,
                         output logic [NP-1:0] d_or);
    logic found;
    found = 1'b0;
    d_or  = '0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (frame_start) begin
        found = 1'b1;
        break;
      end
      d_or |= i2s_d;
      @(negedge clk);
    end
    chk({tag, "_fs_seen"}, 64'(found), 64'd1);
  endtask

  // Present a frame and complete one handshake; s_valid is left high.
  task automatic send(input logic [95:0] d, input string tag);
    logic ok;
    ok      = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_handshake"}, 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic capture(input int unsigned lead, output logic [63:0] ws_c,
                         output logic [63:0] d0_c, output logic [63:0] d1_c);
    ws_c = '0;
    d0_c = '0;
    d1_c = '0;
    repeat (lead) @(negedge clk);
    for (int unsigned i = 0; i < 64; i++) begin
      ws_c[i] = i2s_ws;
      d0_c[i] = i2s_d[0];
      d1_c[i] = i2s_d[1];
      if (i < 63) repeat (8) @(negedge clk);
    end
  endtask

  task automatic run_cycles(input int unsigned n, output logic [NP-1:0] d_or);
    d_or = '0;
    for (int unsigned i = 0; i < n; i++) begin
      d_or |= i2s_d;
      @(negedge clk);
    end
  endtask

  initial begin
    resetb       = 1'b0;
    ena          = 1'b0;
    mode         = 1'b1;
    mute         = 1'b0;
    s_data       = '0;
    s_valid      = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_bck", 64'(i2s_bck), 64'd0);
    chk("rst_ws", 64'(i2s_ws), 64'd0);
    chk("rst_d", 64'(i2s_d), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    resetb = 1'b1;

    bor = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      bor |= i2s_bck;
      @(negedge clk);
    end
    chk("idle_no_bck", 64'(bor), 64'd0);

    // Left-justified, frame loaded while disabled
    send(FR_A, "lj_a");
    s_valid = 1'b0;
    chk("lj_ready_drop", 64'(s_ready), 64'd0);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("first_bck_low", 64'(i2s_bck), 64'd0);
    @(negedge clk);
    chk("first_bck_rise", 64'(i2s_bck), 64'd1);
    wait_fs(600, "lj_first", dor);
    chk("lj_silent_first", 64'(dor), 64'd0);
    chk("lj_ready_back", 64'(s_ready), 64'd1);
    chk("lj_no_underrun", 64'(underrun), 64'd0);
    @(negedge clk);
    chk("fs_one_clk", 64'(frame_start), 64'd0);
    capture(3, cws, cd0, cd1);
    chk("lj_ws", cws, WS_LJ);
    chk("lj_d0", cd0, A_D0);
    chk("lj_d1", cd1, A_D1);

    // Underrun at the next boundary, then clear, then set/clear collision
    chk("ur_before", 64'(underrun), 64'd0);
    wait_fs(32, "ur", dor);
    chk("ur_set", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_cleared", 64'(underrun), 64'd0);
    run_cycles(510, dor);
    chk("ur_frame_zero", 64'(dor), 64'd0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_collide_fs", 64'(frame_start), 64'd1);
    chk("ur_set_wins", 64'(underrun), 64'd1);

    // Disable, underrun is retained, then clear and switch to I2S
    ena = 1'b0;
    @(negedge clk);
    chk("ur_retained", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_clr2", 64'(underrun), 64'd0);
    mode = 1'b0;
    send(FR_A, "i2s_a");
    s_valid = 1'b0;
    ena = 1'b1;
    wait_fs(600, "i2s_first", dor);
    chk("i2s_silent_first", 64'(dor), 64'd0);
    chk("i2s_no_underrun", 64'(underrun), 64'd0);
    @(negedge clk);
    capture(3, cws, cd0, cd1);
    chk("i2s_ws", cws, WS_I2S);
    chk("i2s_d0", cd0, A_D0);
    chk("i2s_d1", cd1, A_D1);

    // Back-pressure: three frames back to back
    send(FR_FA, "bp_fa");
    chk("bp_ready_drop", 64'(s_ready), 64'd0);
    send(FR_FB, "bp_fb");
    chk("bp_ready_drop2", 64'(s_ready), 64'd0);
    chk("bp_no_underrun1", 64'(underrun), 64'd0);
    capture(3, cws, cd0, cd1);
    chk("bp_fa_d0", cd0, FA_D0);
    chk("bp_fa_d1", cd1, FA_D1);
    send(FR_FC, "bp_fc");
    s_valid = 1'b0;
    capture(3, cws, cd0, cd1);
    chk("bp_fb_d0", cd0, FB_D0);
    chk("bp_fb_d1", cd1, FB_D1);
    wait_fs(32, "bp_c", dor);
    chk("bp_no_underrun2", 64'(underrun), 64'd0);
    chk("bp_ready_c", 64'(s_ready), 64'd1);

    // Mute at the next boundary
    send(FR_FA, "mute_fa");
    s_valid = 1'b0;
    mute = 1'b1;
    capture(3, cws, cd0, cd1);
    chk("bp_fc_d0", cd0, FC_D0);
    chk("bp_fc_d1", cd1, FC_D1);
    wait_fs(32, "mute", dor);
    chk("mute_h_empty", 64'(s_ready), 64'd1);
    chk("mute_no_underrun", 64'(underrun), 64'd0);
    mute = 1'b0;
    send(FR_FB, "mute_fb");
    s_valid = 1'b0;
    run_cycles(507, dor);
    chk("mute_frame_zero", 64'(dor), 64'd0);

    // Drop ena mid-frame (bit 33 of frame FB)
    wait_fs(32, "drop", dor);
    send(FR_FC, "drop_fc");
    s_valid = 1'b0;
    repeat (265) @(negedge clk);
    chk("drop_pre_d", 64'(i2s_d), 64'd1);
    chk("drop_pre_ws", 64'(i2s_ws), 64'd1);
    ena = 1'b0;
    @(negedge clk);
    chk("drop_outputs", 64'({i2s_bck, i2s_ws, i2s_d, frame_start}), 64'd0);
    chk("drop_h_kept", 64'(s_ready), 64'd0);
    bor = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      bor |= i2s_bck;
      @(negedge clk);
    end
    chk("drop_no_bck", 64'(bor), 64'd0);

    // Re-enable: silent frame, then the held frame
    ena = 1'b1;
    wait_fs(600, "reen", dor);
    chk("reen_silent", 64'(dor), 64'd0);
    chk("reen_ready", 64'(s_ready), 64'd1);
    chk("reen_no_underrun", 64'(underrun), 64'd0);
    @(negedge clk);
    capture(3, cws, cd0, cd1);
    chk("reen_ws", cws, WS_I2S);
    chk("reen_d0", cd0, FC_D0);
    chk("reen_d1", cd1, FC_D1);

    // Asynchronous reset mid-frame with BCK high and data active
    send(FR_FA, "ar_fa");
    s_valid = 1'b0;
    wait_fs(32, "ar", dor);
    send(FR_FB, "ar_fb");
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("ar_pre_bck", 64'(i2s_bck), 64'd1);
    chk("ar_pre_d", 64'(i2s_d), 64'd1);
    chk("ar_pre_ready", 64'(s_ready), 64'd0);
    #2;
    resetb = 1'b0;
    #1;
    chk("ar_outputs", 64'({i2s_bck, i2s_ws, i2s_d, frame_start, underrun}), 64'd0);
    chk("ar_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toi2s_i2s_tx_multi.md
# toi2s_i2s_tx_multi

Parametrised multi-channel I2S transmitter for the toi2s audio path: accepts frames of signed PCM samples over a valid/ready handshake and serialises them onto `NPAIR` stereo data lines sharing one BCK/WS pair. It supersedes the fixed single-line stereo I2S output that drives the amplifier (`amp_i2s_bck/ws/d0`). It adds configurable sample and slot width, BCK division, I2S or left-justified framing, mute, and underrun detection.

## Interface
- `SAMPLE_W`, 24: bits per sample, two's complement, MSB first; 1 ≤ SAMPLE_W ≤ SLOT_W.
- `SLOT_W`, 32: BCK periods per channel slot; frame length = 2·SLOT_W BCK periods.
- `NPAIR`, 1: number of stereo data lines.
- `BCK_DIV`, 4: clk cycles per BCK half-period, ≥ 1.

Ports:
- `clk` in 1: system clock.
- `resetb` in 1: asynchronous active-low reset.
- `ena` in 1: run enable; low holds the serialiser idle.
- `mode` in 1: 0 = I2S (WS leads data by one BCK), 1 = left-justified.
- `mute` in 1: when high, frames loaded at a boundary are forced to zero.
- `s_data` in 2·NPAIR·SAMPLE_W: pair p left = `s_data[2p·SAMPLE_W +: SAMPLE_W]`, right = `s_data[(2p+1)·SAMPLE_W +: SAMPLE_W]`.
- `s_valid` in 1 / `s_ready` out 1: input frame handshake.
- `i2s_bck` out 1, `i2s_ws` out 1 (0 = left), `i2s_d` out NPAIR.
- `frame_start` out 1: one-clk pulse at each frame wrap.
- `underrun` out 1: sticky underrun flag. `underrun_clr` in 1: clears it.

## Operation
- Single-entry holding register (H) plus shadow shift register (S). `s_ready` = H empty. A transfer occurs when `s_valid` and `s_ready` are high on the same clk edge; it fills H.
- Divider `div` counts 0..BCK_DIV−1. At terminal count, `i2s_bck` toggles. A falling event is a terminal count while `i2s_bck`=1.
- Bit counter `bit` runs 0..2·SLOT_W−1 and advances on each falling event, wrapping to 0.
- Slot index k = bit mod SLOT_W. Channel = left if bit < SLOT_W, else right.
- `i2s_d[p]` = S sample bit [SAMPLE_W−1−k] for k < SAMPLE_W, else 0.
- `i2s_ws`:
  - LJ mode: (bit ≥ SLOT_W).
  - I2S mode: (((bit+1) mod 2·SLOT_W) ≥ SLOT_W), so WS changes one BCK before the MSB.
- Frame boundary = falling event where `bit` wraps to 0. H state is sampled before any same-cycle handshake.
  - H full: S ← H (or zeros if `mute`=1), H emptied.
  - H empty: S ← 0 and `underrun` ← 1.
  - A same-cycle handshake into an empty H still fills H; that frame is used at the next boundary.
- `underrun_clr` clears the flag. If a new underrun occurs in the same cycle, set wins.
- `ena` low (synchronous): `div`, `bit` and S are cleared; `i2s_bck/ws/d`=0; `frame_start`=0. H and `underrun` are retained, and the handshake stays live.
- `ena` rising: the first frame starts at bit 0 with S=0 (silent). No underrun is flagged for this frame because it is not a boundary.
- `mode` changes take effect at the next falling event. Change `mode` only while `ena`=0.

## Timing
- Reset values: `i2s_bck`=0, `i2s_ws`=0, `i2s_d`=0, `frame_start`=0, `underrun`=0, `s_ready`=1. Reset also clears H, S, `div` and `bit`.
- All outputs are registered. `i2s_ws` and `i2s_d` update on the same clk edge that drives `i2s_bck` low.
- BCK period = 2·BCK_DIV clk. With default parameters, frame = 2·SLOT_W·2·BCK_DIV = 512 clk.
- After `ena` rises, the first `i2s_bck` rise occurs BCK_DIV clk later.
- `frame_start` is high for exactly one clk, on the edge where `bit` becomes 0 at a boundary.
- `s_ready` deasserts the clk after a handshake. It reasserts the clk after the boundary that empties H.
- An underrun is visible on `underrun` the clk after the boundary.

## Test plan
- Reset: assert `resetb`=0 mid-frame → all outputs 0 and `s_ready`=1 immediately (asynchronous); no BCK activity while `ena`=0.
- LJ, defaults: send L=0x800001, R=0x7FFFFF, then enable → frame 2 shows WS low for 32 BCK. Data is 1,0…0,1 then eight 0s. Right slot shows 0 then twenty-three 1s then zeros.
- I2S mode, same data → WS falls one BCK before the left MSB and rises one BCK before the right MSB; data bits are identical to LJ.
- Underrun: hold `s_valid`=0 across a boundary → `underrun`=1 one clk later and the frame outputs zero. Pulse `underrun_clr` → 0. Set and clear in the same cycle → remains 1.
- Back-pressure, NPAIR=2: present three frames back to back → `s_ready` drops after the first handshake and each frame is consumed at successive boundaries in order. Pair 1 carries its own samples.
- Mute / `ena` drop: `mute`=1 at a boundary → S loads zeros and H empties. Dropping `ena` mid-frame → outputs 0 the next clk. Re-enabling → a silent first frame, then the held H frame.
